// File: rtl/mdu.sv
// HI/LO multiply/divide unit: mult/multu busy MULT_CYCLES, div/divu busy DIV_CYCLES, mthi/mtlo in one edge.
// No backpressure input; md_stall asks the hazard unit to hold the issuing stage while an op is pending.
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        cancel,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = ($clog2(CMAX + 1) > 4) ? $clog2(CMAX + 1) : 4;
   localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

   logic [31:0]   r_hi, r_lo, r_res_hi, r_res_lo;
   logic [CW-1:0] r_cnt;
   logic          r_busy, r_dbz;

   logic               w_long, w_accept;
   logic signed [63:0] w_prod_s;
   logic [63:0]        w_prod_u;
   logic               w_a_neg, w_b_neg;
   logic [31:0]        w_a_mag, w_b_mag, w_b_div, w_q_mag, w_r_mag, w_q, w_r;

   assign w_long   = (md_op == 3'd1) || (md_op == 3'd2) || (md_op == 3'd3) || (md_op == 3'd4);
   assign w_accept = (md_op != 3'd0) && (md_op != 3'd7) && !cancel && !r_busy;
   assign md_stall = r_busy | (w_long & ~cancel);

   assign w_prod_s = $signed(A) * $signed(B);
   assign w_prod_u = {32'd0, A} * {32'd0, B};

   // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without relying on signed-overflow semantics.
   assign w_a_neg = (md_op == 3'd3) & A[31];
   assign w_b_neg = (md_op == 3'd3) & B[31];
   assign w_a_mag = w_a_neg ? -A : A;
   assign w_b_mag = w_b_neg ? -B : B;
   assign w_b_div = (B == 32'd0) ? 32'd1 : w_b_mag;
   assign w_q_mag = w_a_mag / w_b_div;
   assign w_r_mag = w_a_mag % w_b_div;
   assign w_q     = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
   assign w_r     = w_a_neg ? -w_r_mag : w_r_mag;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
         r_res_hi <= 32'd0;
         r_res_lo <= 32'd0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_dbz    <= 1'b0;
      end else if (r_busy) begin
         r_cnt <= r_cnt - 1'b1;
         if (r_cnt == CW'(1)) begin
            r_busy <= 1'b0;
            if (!r_dbz) begin
               r_hi <= r_res_hi;
               r_lo <= r_res_lo;
            end
         end
      end else if (w_accept) begin
         case (md_op)
            3'd1, 3'd2: begin
               {r_res_hi, r_res_lo} <= (md_op == 3'd1) ? w_prod_s : w_prod_u;
               r_dbz  <= 1'b0;
               r_cnt  <= MULT_N;
               r_busy <= 1'b1;
            end
            3'd3, 3'd4: begin
               r_res_hi <= w_r;
               r_res_lo <= w_q;
               r_dbz    <= (B == 32'd0);
               r_cnt    <= DIV_N;
               r_busy   <= 1'b1;
            end
            3'd5:    r_hi <= A;
            3'd6:    r_lo <= A;
            default: ;
         endcase
      end
   end

   assign busy = r_busy;
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Directed + randomized bench for mdu: expected HI/LO queued at issue, popped and compared at completion.
module tb_mdu;
   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  md_op;
   logic [31:0] A, B;
   logic        cancel;
   logic        busy, md_stall;
   logic [31:0] HI, LO;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] sb_q[$];
   logic [31:0] m_hi, m_lo;

   mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .md_op(md_op), .A(A), .B(B), .cancel(cancel),
      .busy(busy), .md_stall(md_stall), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [63:0] old);
      longint sa, sb, q, r;
      logic [63:0] p;
      case (op)
         3'd1: begin
            sa = $signed(a);
            sb = $signed(b);
            p  = sa * sb;
            return p;
         end
         3'd2: begin
            p = {32'd0, a} * {32'd0, b};
            return p;
         end
         3'd3, 3'd4: begin
            if (b == 32'd0) return old;
            if (op == 3'd3) begin
               sa = $signed(a);
               sb = $signed(b);
            end else begin
               sa = {32'd0, a};
               sb = {32'd0, b};
            end
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: return old;
      endcase
   endfunction

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic c);
      md_op  = op;
      A      = a;
      B      = b;
      cancel = c;
      #1;
      check("stall_issue", {31'd0, md_stall}, {31'd0, (op >= 3'd1 && op <= 3'd4 && !c)});
      tick();
      md_op  = 3'd0;
      cancel = 1'b0;
      A      = $urandom;
      B      = $urandom;
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit intf);
      int          cyc;
      int          n;
      logic [63:0] e;
      n = (op <= 3'd2) ? 5 : 10;
      sb_q.push_back(exp);
      issue(op, a, b, 1'b0);
      check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
      cyc = 0;
      while (busy === 1'b1 && cyc < 40) begin
         check({tag, "_hi_hold"}, HI, m_hi);
         check({tag, "_lo_hold"}, LO, m_lo);
         check({tag, "_stall"}, {31'd0, md_stall}, 32'd1);
         if (intf && cyc == 1) begin
            md_op = 3'd4; A = 32'h0000DEAD; B = 32'd3;
         end else if (intf && cyc == 2) begin
            md_op = 3'd6; A = 32'h0000DEAD;
         end else begin
            md_op = 3'd0;
         end
         tick();
         cyc++;
      end
      md_op = 3'd0;
      check({tag, "_cycles"}, cyc, n);
      e = sb_q.pop_front();
      check({tag, "_hi"}, HI, e[63:32]);
      check({tag, "_lo"}, LO, e[31:0]);
      m_hi = e[63:32];
      m_lo = e[31:0];
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] ra, rb;
      reset = 1'b0; md_op = 3'd0; A = '0; B = '0; cancel = 1'b0;
      m_hi = '0; m_lo = '0;
      #12;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_stall", {31'd0, md_stall}, 32'd0);
      check("rst_hi", HI, 32'd0);
      check("rst_lo", LO, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      tick();

      run_op("mult", 3'd1, 32'hFFFFFFFD, 32'd5, {32'hFFFFFFFF, 32'hFFFFFFF1}, 1'b0);
      run_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, {32'h00000001, 32'hFFFFFFFE}, 1'b0);
      run_op("div", 3'd3, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0);

      issue(3'd5, 32'h11, 32'd0, 1'b0);
      check("mthi_val", HI, 32'h11);
      check("mthi_busy", {31'd0, busy}, 32'd0);
      issue(3'd6, 32'h22, 32'd0, 1'b0);
      check("mtlo_val", LO, 32'h22);
      m_hi = 32'h11; m_lo = 32'h22;

      run_op("divu0", 3'd4, 32'd7, 32'd0, {32'h11, 32'h22}, 1'b0);
      run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 1'b0);

      issue(3'd5, 32'h12345678, 32'd0, 1'b0);
      check("mthi2_val", HI, 32'h12345678);
      check("mthi2_busy", {31'd0, busy}, 32'd0);
      m_hi = 32'h12345678;
      issue(3'd6, 32'h0000ABCD, 32'd0, 1'b1);
      check("mtlo_cancel", LO, m_lo);
      issue(3'd1, 32'd3, 32'd3, 1'b1);
      check("mult_cancel_busy", {31'd0, busy}, 32'd0);

      run_op("mult_intf", 3'd1, 32'd6, 32'd7, {32'd0, 32'd42}, 1'b1);
      tick();
      check("intf_idle", {31'd0, busy}, 32'd0);
      check("intf_lo", LO, 32'd42);

      for (int i = 0; i < 8; i++) begin
         op = 3'($urandom_range(1, 4));
         ra = $urandom;
         rb = (i == 5) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
         run_op("rand", op, ra, rb, model(op, ra, rb, {m_hi, m_lo}), 1'b0);
      end

      issue(3'd3, 32'd100, 32'd3, 1'b0);
      tick(); tick(); tick();
      #2;
      reset = 1'b0;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_hi", HI, 32'd0);
      check("arst_lo", LO, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      m_hi = '0; m_lo = '0;
      for (int i = 0; i < 12; i++) tick();
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      check("post_rst_hi", HI, 32'd0);
      check("post_rst_lo", LO, 32'd0);
      check("sb_empty", sb_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the E stage of the five-stage MIPS pipeline, directly downstream of the decode stage. It executes mult, multu, div, divu, mthi and mtlo against private HI/LO registers with multi-cycle latency. It raises a stall request that the hazard unit uses to hold D-stage HI/LO-dependent instructions. HI and LO feed the E-stage result mux for mfhi/mflo.

## Interface
- Parameters:
  - MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
  - DIV_CYCLES, 10, busy cycles for div/divu (≥1)
- Ports:
  - clk  in  1  pipeline clock, all state on rising edge
  - reset  in  1  asynchronous, active-low (0 = reset), one clock domain
  - md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
  - A  in  32  rs operand (forwarded)
  - B  in  32  rt operand (forwarded)
  - cancel  in  1  E-stage instruction is being flushed (exception/interrupt in M); suppresses this cycle's md_op
  - busy  out  1  registered, operation in flight
  - md_stall  out  1  combinational: busy | (md_op∈{1..4} & !cancel)
  - HI  out  32  architectural HI
  - LO  out  32  architectural LO

## Operation
- Registers: HI, LO, res_hi, res_lo (pending result), cnt (4 bits minimum, sized to max(MULT_CYCLES, DIV_CYCLES)), busy.
- Reset (reset=0, asynchronous): HI=0, LO=0, res_hi=0, res_lo=0, cnt=0, busy=0. Any in-flight result is discarded.
- An op is accepted on a rising edge when md_op≠0, md_op≠7, cancel=0, busy=0. Ops presented while busy=1 are ignored; the hazard unit guarantees they don't occur. The bench checks that they are ignored.
- Accepted ops:
  - mult: {res_hi,res_lo} = $signed(A)*$signed(B), 64-bit. cnt=MULT_CYCLES, busy=1.
  - multu: unsigned 64-bit product. Same timing as mult.
  - div: res_lo = signed quotient truncated toward zero, res_hi = remainder with the sign of the dividend. cnt=DIV_CYCLES, busy=1.
  - divu: unsigned quotient/remainder. Same timing as div.
  - mthi: HI=A on the same edge. No busy.
  - mtlo: LO=A on the same edge. No busy.
- Division boundary cases:
  - Divide by zero (B=0, div or divu): op is accepted and busy runs DIV_CYCLES, but HI/LO are left unchanged at completion.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): LO=0x80000000, HI=0.
- In-flight: each edge with busy=1, cnt decrements. On the edge where cnt goes 1→0: HI=res_hi, LO=res_lo (unless divide-by-zero), busy=0.
- cancel=1 suppresses acceptance of every md_op, including mthi/mtlo. cancel has no effect on an operation already in flight; that operation completes normally.
- HI/LO never change mid-operation. The new values appear only at completion.

## Timing
- Operands are sampled only at the accept edge. A/B may change afterwards.
- Accept at edge T0:
  - busy=1 from T0.
  - HI/LO updated and busy=0 at edge T0+N, where N=MULT_CYCLES or DIV_CYCLES.
  - busy is high for exactly N cycles.
- md_stall is high in the accept cycle (before T0) and in all N busy cycles.
- mthi/mtlo: 1-cycle write with no stall. The new HI/LO value is visible on the outputs immediately after the edge.
- Back-to-back: a new op may be accepted on the edge after busy falls, i.e. in the first cycle with busy=0.
- Reset asserted mid-operation: outputs go to their reset values immediately, without waiting for a clock edge. After reset deasserts, the unit is idle.

## Test plan
- mult A=0xFFFFFFFD (−3), B=5 -> busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1. HI/LO unchanged during the busy window.
- multu A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE. Then div A=0xFFFFFFF9 (−7), B=2 issued the next cycle -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu A=7, B=0 with prior HI=0x11, LO=0x22 -> busy for 10 cycles, then HI=0x11, LO=0x22. Signed div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi A=0x12345678 -> HI=0x12345678 after 1 edge, busy stays 0. mtlo A=0xABCD with cancel=1 -> LO unchanged, md_stall=0.
- Start mult, then present divu and mtlo during the busy window -> both ignored. The mult result is committed at cycle 5, and md_stall stays high throughout.
- Start div, then assert reset=0 asynchronously at cycle 4 -> busy, HI and LO go to 0 without a clock edge. After release, no commit occurs at cycle 10.
